display_scan_ctrl: RTL

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It shares the single combinational hex-to-7-segment decoder (active-low segments) among all digits. It steps through the digits, drives the nibble for the current digit into the decoder, and asserts the matching active-low anode. A frame-synchronous shadow register lets software update the displayed value atomically, with no tearing.

---
 rtl/display_scan_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Shares one hex nibble path across digits; a shadow register allows tear-free updates.
module display_scan_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   digit_en,
  output logic [3:0]            hex_digit,
  output logic [N_DIGITS-1:0]   an,
  output logic                  dp_n,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_CNT = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DIGITS - 1);

  typedef enum logic {GUARD, SHOW} state_t;

  state_t                state, nxt_state;
  logic [CNT_W-1:0]      cnt, nxt_cnt;
  logic [IDX_W-1:0]      idx, nxt_idx;
  logic [4*N_DIGITS-1:0] active, shadow, nxt_active;
  logic [N_DIGITS-1:0]   active_dp, shadow_dp, nxt_active_dp;
  logic [N_DIGITS-1:0]   nxt_an;
  logic                  nxt_dp_n;
  logic [3:0]            nxt_hex;
  logic                  slot_end, frame_end;

  // Outputs are derived from next-state values so the registered outputs line
  // up with the counter/index they describe in the same cycle.
  always_comb begin
    slot_end      = (cnt == LAST_CNT);
    frame_end     = slot_end && (idx == LAST_IDX);
    nxt_cnt       = slot_end ? '0 : cnt + 1'b1;
    nxt_idx       = idx;
    if (frame_end)
      nxt_idx = '0;
    else if (slot_end)
      nxt_idx = idx + 1'b1;

    nxt_state = state;
    case (state)
      GUARD: nxt_state = (nxt_cnt == BLANK_CNT) ? SHOW : GUARD;
      SHOW:  nxt_state = slot_end ? GUARD : SHOW;
      default: nxt_state = GUARD;
    endcase

    nxt_active    = active;
    nxt_active_dp = active_dp;
    if (frame_end && load) begin
      nxt_active    = value_in;
      nxt_active_dp = dp_in;
    end else if (frame_end && pending) begin
      nxt_active    = shadow;
      nxt_active_dp = shadow_dp;
    end

    nxt_an = '1;
    if (nxt_state == SHOW && digit_en[nxt_idx])
      nxt_an[nxt_idx] = 1'b0;
    nxt_dp_n = !(nxt_state == SHOW && nxt_active_dp[nxt_idx] && digit_en[nxt_idx]);
    nxt_hex  = nxt_active[{nxt_idx, 2'b00} +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= GUARD;
      cnt        <= '0;
      idx        <= '0;
      active     <= '0;
      active_dp  <= '0;
      shadow     <= '0;
      shadow_dp  <= '0;
      pending    <= 1'b0;
      an         <= '1;
      dp_n       <= 1'b1;
      hex_digit  <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      idx        <= nxt_idx;
      active     <= nxt_active;
      active_dp  <= nxt_active_dp;
      an         <= nxt_an;
      dp_n       <= nxt_dp_n;
      hex_digit  <= nxt_hex;
      frame_tick <= frame_end;
      if (load) begin
        shadow    <= value_in;
        shadow_dp <= dp_in;
      end
      // A load on the boundary edge goes straight to active, so pending clears either way.
      if (frame_end)
        pending <= 1'b0;
      else if (load)
        pending <= 1'b1;
    end
  end

endmodule
